config_frame_loader: RTL and testbench

//  Write-side driver for the fabric configuration latch array. Accepts a byte stream
//  (valid/ready), assembles one frame of FRAME_BITS, presents it on FrameData and

---
 rtl/config_frame_loader.sv | 127 ++++++++++++
 tb/tb_config_frame_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_loader.sv
// Configuration frame loader: assembles a header + FRAME_BITS payload from a byte stream
// and drives FrameData plus one registered one-hot FrameStrobe pulse per frame.
module config_frame_loader #(
   parameter int IN_W       = 8,
   parameter int FRAME_BITS = 32,
   parameter int NUM_FRAMES = 20,
   parameter int STROBE_LEN = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [IN_W-1:0]       s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  err_clr,
   output logic [FRAME_BITS-1:0] FrameData,
   output logic [NUM_FRAMES-1:0] FrameStrobe,
   output logic                  busy,
   output logic                  err,
   output logic [15:0]           frames_done
);

   localparam int BEATS = FRAME_BITS / IN_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LEN_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

   typedef enum logic [2:0] {IDLE, DATA, SETUP, STROBE, HOLD} state_t;

   state_t                state_reg, state_next;
   logic [6:0]            index_reg;
   logic                  discard_reg;
   logic [CNT_W-1:0]      beat_cnt_reg;
   logic [LEN_W-1:0]      len_cnt_reg;
   logic [FRAME_BITS-1:0] shift_reg, shift_next;
   logic [FRAME_BITS-1:0] frame_data_reg;
   logic [NUM_FRAMES-1:0] strobe_reg, strobe_sel;
   logic                  err_reg;
   logic [15:0]           frames_done_reg;

   logic accept, is_header, bad_header, last_beat, strobe_done;

   assign s_ready     = (state_reg == IDLE) || (state_reg == DATA);
   assign busy        = (state_reg != IDLE);
   assign FrameData   = frame_data_reg;
   assign FrameStrobe = strobe_reg;
   assign err         = err_reg;
   assign frames_done = frames_done_reg;

   assign accept      = s_valid && s_ready;
   assign is_header   = (state_reg == IDLE) && accept && s_data[IN_W-1];
   assign bad_header  = is_header && (s_data[6:0] >= 7'(NUM_FRAMES));
   assign last_beat   = (state_reg == DATA) && accept && (beat_cnt_reg == CNT_W'(BEATS - 1));
   assign strobe_done = (len_cnt_reg == LEN_W'(STROBE_LEN - 1));

   // The last beat is folded in combinationally so FrameData can load on the same edge.
   generate
      if (BEATS > 1) begin : g_shift_multi
         assign shift_next = {shift_reg[FRAME_BITS-IN_W-1:0], s_data};
      end else begin : g_shift_single
         assign shift_next = s_data;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FRAMES; gi++) begin : g_onehot
         assign strobe_sel[gi] = (index_reg == 7'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (is_header) state_next = DATA;
         DATA:   if (last_beat) state_next = discard_reg ? IDLE : SETUP;
         SETUP:  state_next = STROBE;
         STROBE: if (strobe_done) state_next = HOLD;
         HOLD:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg       <= IDLE;
         index_reg       <= '0;
         discard_reg     <= 1'b0;
         beat_cnt_reg    <= '0;
         len_cnt_reg     <= '0;
         shift_reg       <= '0;
         frame_data_reg  <= '0;
         strobe_reg      <= '0;
         err_reg         <= 1'b0;
         frames_done_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (is_header) begin
            index_reg    <= s_data[6:0];
            discard_reg  <= bad_header;
            beat_cnt_reg <= '0;
         end else if ((state_reg == DATA) && accept) begin
            shift_reg    <= shift_next;
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
         end

         if (last_beat && !discard_reg)
            frame_data_reg <= shift_next;

         if (state_reg == STROBE)
            len_cnt_reg <= len_cnt_reg + 1'b1;
         else
            len_cnt_reg <= '0;

         strobe_reg <= (state_next == STROBE) ? strobe_sel : '0;

         // A bad header arriving with err_clr still leaves err set.
         if (bad_header)
            err_reg <= 1'b1;
         else if (err_clr)
            err_reg <= 1'b0;

         if (state_reg == HOLD)
            frames_done_reg <= frames_done_reg + 16'd1;
      end
   end

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: stimulus queues expected frames, a monitor
// checks every strobe pulse; directed checks cover reset, errors, timing and wrap.
module tb_config_frame_loader;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic        sel = 1'b0;

   logic        s_ready, busy, err;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
   logic [15:0] frames_done;

   logic        s_ready3, busy3, err3;
   logic [31:0] FrameData3;
   logic [19:0] FrameStrobe3;
   logic [15:0] frames_done3;

   logic valid1, valid3, rdy_sel;
   assign valid1  = s_valid && !sel;
   assign valid3  = s_valid && sel;
   assign rdy_sel = sel ? s_ready3 : s_ready;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [19:0] strobe;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   config_frame_loader #(.IN_W(8), .FRAME_BITS(32), .NUM_FRAMES(20), .STROBE_LEN(1)) dut (
      .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(valid1), .s_ready(s_ready),
      .err_clr(err_clr), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
      .err(err), .frames_done(frames_done));

   config_frame_loader #(.IN_W(8), .FRAME_BITS(32), .NUM_FRAMES(20), .STROBE_LEN(3)) dut3 (
      .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(valid3), .s_ready(s_ready3),
      .err_clr(err_clr), .FrameData(FrameData3), .FrameStrobe(FrameStrobe3), .busy(busy3),
      .err(err3), .frames_done(frames_done3));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      @(negedge CLK);
      s_data  = b;
      s_valid = 1'b1;
      n = 0;
      while (!rdy_sel && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 100) chk("send_ready_timeout", 64'(n), 64'(0));
      @(posedge CLK);
      #1 s_valid = 1'b0;
      $display("tx byte=0x%02h sel=%0d", b, sel);
   endtask

   task automatic expect_frame(input int idx, input logic [31:0] d);
      exp_t e;
      e.strobe = 20'(1) << idx;
      e.data   = d;
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [31:0] d, input int gap);
      send(hdr);
      for (int i = 3; i >= 0; i--) begin
         repeat (gap) @(negedge CLK);
         send(d[i*8 +: 8]);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge CLK);
      while (busy && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) chk("wait_idle_timeout", 64'(n), 64'(0));
   endtask

   // Monitor: pops one expectation per strobe pulse and checks length and data stability.
   initial begin : monitor
      bit          in_strobe;
      bit          hold_chk;
      int          len;
      logic [31:0] saved, prev_data;
      exp_t        e;
      in_strobe = 0; hold_chk = 0; len = 0; saved = '0; prev_data = '0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            in_strobe = 0; hold_chk = 0; len = 0; prev_data = FrameData;
            continue;
         end
         if (hold_chk) begin
            chk("mon_data_after_fall", 64'(FrameData), 64'(saved));
            hold_chk = 0;
         end
         if (FrameStrobe != '0) begin
            if (!in_strobe) begin
               if (exp_q.size() == 0) begin
                  chk("mon_unexpected_strobe", 64'(FrameStrobe), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("mon_strobe", 64'(FrameStrobe), 64'(e.strobe));
                  chk("mon_data", 64'(FrameData), 64'(e.data));
                  chk("mon_data_before_rise", 64'(prev_data), 64'(e.data));
                  $display("rx strobe=0x%05h data=0x%08h", FrameStrobe, FrameData);
               end
               in_strobe = 1; len = 1; saved = FrameData;
            end else begin
               len++;
               chk("mon_data_during_strobe", 64'(FrameData), 64'(saved));
            end
         end else if (in_strobe) begin
            chk("mon_strobe_len", 64'(len), 64'(1));
            in_strobe = 0;
            hold_chk = 1;
         end
         prev_data = FrameData;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int cnt;
      // Reset values
      #12;
      chk("rst_strobe", 64'(FrameStrobe), 64'(0));
      chk("rst_data", 64'(FrameData), 64'(0));
      chk("rst_ready", 64'(s_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_frames_done", 64'(frames_done), 64'(0));
      @(negedge CLK);
      #3 RESET = 1'b0;

      // Single frame to index 3 with cycle-exact handshake timing
      expect_frame(3, 32'hDEADBEEF);
      send_frame(8'h83, 32'hDEADBEEF, 0);
      @(negedge CLK);
      chk("t2_setup_data", 64'(FrameData), 64'hDEADBEEF);
      chk("t2_setup_strobe", 64'(FrameStrobe), 64'(0));
      chk("t2_setup_ready", 64'(s_ready), 64'(0));
      @(negedge CLK);
      chk("t2_strobe", 64'(FrameStrobe), 64'h00008);
      chk("t2_strobe_ready", 64'(s_ready), 64'(0));
      @(negedge CLK);
      chk("t2_hold_strobe", 64'(FrameStrobe), 64'(0));
      chk("t2_hold_ready", 64'(s_ready), 64'(0));
      @(negedge CLK);
      chk("t2_ready_back", 64'(s_ready), 64'(1));
      chk("t2_frames_done", 64'(frames_done), 64'(1));

      // Bad frame index: discarded, err sticky, err_clr clears, set wins over clear
      send_frame(8'h94, 32'h12345678, 0);
      wait_idle();
      chk("t3_err_set", 64'(err), 64'(1));
      chk("t3_frames_done", 64'(frames_done), 64'(1));
      chk("t3_data_kept", 64'(FrameData), 64'hDEADBEEF);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      chk("t3_err_clr", 64'(err), 64'(0));
      err_clr = 1'b1;
      send(8'h95);
      err_clr = 1'b0;
      chk("t3_set_wins", 64'(err), 64'(1));
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
      wait_idle();
      chk("t3_err_still", 64'(err), 64'(1));
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;

      // Back-to-back frames 0 and 19 with s_valid gaps inside DATA
      expect_frame(0, 32'h01234567);
      send_frame(8'h80, 32'h01234567, 2);
      expect_frame(19, 32'h89ABCDEF);
      send_frame(8'h93, 32'h89ABCDEF, 1);
      wait_idle();
      @(negedge CLK);
      chk("t4_frames_done", 64'(frames_done), 64'(3));
      chk("t4_data", 64'(FrameData), 64'h89ABCDEF);

      // Reset asserted while the strobe is high
      expect_frame(5, 32'hCAFEF00D);
      send_frame(8'h85, 32'hCAFEF00D, 0);
      @(negedge CLK);
      @(negedge CLK);
      chk("t1_pre_strobe", 64'(FrameStrobe), 64'h00020);
      #2 RESET = 1'b1;
      #1;
      chk("t1_strobe_drop", 64'(FrameStrobe), 64'(0));
      chk("t1_data_clear", 64'(FrameData), 64'(0));
      chk("t1_ready", 64'(s_ready), 64'(1));
      chk("t1_busy", 64'(busy), 64'(0));
      chk("t1_frames_done", 64'(frames_done), 64'(0));
      @(negedge CLK);
      #3 RESET = 1'b0;

      // frames_done wrap from 0xFFFF
      @(negedge CLK);
      force dut.frames_done_reg = 16'hFFFF;
      @(negedge CLK);
      release dut.frames_done_reg;
      @(negedge CLK);
      chk("t6_preload", 64'(frames_done), 64'hFFFF);
      expect_frame(2, 32'h0BADF00D);
      send_frame(8'h82, 32'h0BADF00D, 0);
      wait_idle();
      chk("t6_wrap", 64'(frames_done), 64'(0));

      // STROBE_LEN=3 instance: ignored header, then a 3-cycle strobe
      sel = 1'b1;
      send(8'h05);
      @(negedge CLK);
      chk("t5_busy_ignored", 64'(busy3), 64'(0));
      chk("t5_ready_ignored", 64'(s_ready3), 64'(1));
      send_frame(8'h87, 32'h11223344, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (FrameStrobe3 != '0) begin
            cnt++;
            chk("t5_strobe", 64'(FrameStrobe3), 64'h00080);
            chk("t5_data", 64'(FrameData3), 64'h11223344);
         end
      end
      chk("t5_strobe_len", 64'(cnt), 64'(3));
      chk("t5_frames_done", 64'(frames_done3), 64'(1));
      chk("t5_idle", 64'(busy3), 64'(0));
      sel = 1'b0;

      repeat (3) @(negedge CLK);
      chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
